// File: rtl/game_pkg.sv
// Shared definitions for the game / end-of-game display slice:
// FSM encoding, score ceiling, view codes and the player-count clamp.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int unsigned MAX_SCORE   = 99;
    localparam int unsigned MAX_PLAYERS = 4;

    // View codes understood by the top-level view mux.
    localparam logic [1:0] VIEW_MENU = 2'd0;
    localparam logic [1:0] VIEW_PLAY = 2'd1;
    localparam logic [1:0] VIEW_WIN  = 2'd2;

    localparam logic [2:0] NO_WINNER = 3'd0;

    function automatic logic [2:0] clamp_players(input logic [2:0] n);
        logic [2:0] r;
        r = n;
        if (n == 3'd0) begin
            r = 3'd1;
        end else if (n > 3'(MAX_PLAYERS)) begin
            r = 3'(MAX_PLAYERS);
        end
        return r;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-control and end-of-game display bus between the game-play logic
// (master) and score_keeper (slave).
interface score_keeper_if;

    logic       start;
    logic [2:0] player_count_in;
    logic       award_valid;
    logic       award_ready;
    logic [2:0] award_player;
    logic       award_sub;
    logic [3:0] award_pts;
    logic [2:0] player_count;
    logic [6:0] player1_score;
    logic [6:0] player2_score;
    logic [6:0] player3_score;
    logic [6:0] player4_score;
    logic [2:0] winner;
    logic       game_over;
    logic       win_req;

    modport master (
        output start, player_count_in,
        output award_valid, award_player, award_sub, award_pts,
        input  award_ready,
        input  player_count, player1_score, player2_score, player3_score, player4_score,
        input  winner, game_over, win_req
    );

    modport slave (
        input  start, player_count_in,
        input  award_valid, award_player, award_sub, award_pts,
        output award_ready,
        output player_count, player1_score, player2_score, player3_score, player4_score,
        output winner, game_over, win_req
    );

endinterface

// File: rtl/score_keeper_score_sat.sv
// Saturating score update: 7-bit score plus/minus 4-bit points, computed
// 8 bits wide and clamped to 0..MAX_SCORE.
module score_sat
    import game_pkg::*;
(
    input  logic [6:0] score_i,
    input  logic [3:0] pts_i,
    input  logic       sub_i,
    output logic [6:0] score_o
);

    logic [7:0] sum;
    logic [7:0] diff;

    assign sum  = {1'b0, score_i} + {4'b0, pts_i};
    // Score <= 127 and pts <= 15, so bit 7 of the difference flags underflow.
    assign diff = {1'b0, score_i} - {4'b0, pts_i};

    always_comb begin
        if (sub_i) begin
            score_o = diff[7] ? 7'd0 : diff[6:0];
        end else begin
            score_o = (sum > 8'(MAX_SCORE)) ? 7'(MAX_SCORE) : sum[6:0];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: owns player scores, ends the game and picks the winner.
// Optional round limit enabled by defining SCORE_KEEPER_ROUND_LIMIT_EN.
module score_keeper
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE  = 30
`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
   ,parameter int unsigned MAX_ROUNDS = 20
`endif
) (
    input logic           clk,
    input logic           rst,
    score_keeper_if.slave bus
);

    state_e          state_q, state_d;
    logic [2:0]      player_count_q, player_count_d;
    logic [3:0][6:0] score_q, score_d;
    logic [2:0]      winner_q, winner_d;
    logic            win_req_q, win_req_d;
    logic [2:0]      scan_idx_q, scan_idx_d;
    logic [2:0]      best_idx_q, best_idx_d;
    logic [6:0]      best_score_q, best_score_d;
`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
    logic [4:0]      round_q, round_d;
`endif

    logic       award_hit;
    logic       player_ok;
    logic [1:0] award_sel;
    logic [6:0] sat_score;
    logic [1:0] scan_sel;
    logic [6:0] scan_score;
    logic       take;
    logic       win_hit;
    logic       round_hit;
    logic       end_hit;

    assign bus.award_ready = (state_q == ST_PLAY);
    assign award_hit       = bus.award_valid && bus.award_ready;
    assign player_ok       = (bus.award_player != 3'd0) && (bus.award_player <= player_count_q);
    assign award_sel       = 2'(bus.award_player - 3'd1);
    assign scan_sel        = 2'(scan_idx_q - 3'd1);
    assign scan_score      = score_q[scan_sel];

    score_sat u_score_sat (
        .score_i (score_q[award_sel]),
        .pts_i   (bus.award_pts),
        .sub_i   (bus.award_sub),
        .score_o (sat_score)
    );

    always_comb begin
        win_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (32'(score_q[i]) >= WIN_SCORE) begin
                win_hit = 1'b1;
            end
        end
    end

`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
    assign round_hit = (round_q == 5'(MAX_ROUNDS));
`else
    assign round_hit = 1'b0;
`endif
    assign end_hit = win_hit || round_hit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d        = state_q;
        player_count_d = player_count_q;
        score_d        = score_q;
        winner_d       = winner_q;
        win_req_d      = 1'b0;
        scan_idx_d     = scan_idx_q;
        best_idx_d     = best_idx_q;
        best_score_d   = best_score_q;
        take           = 1'b0;
`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
        round_d        = round_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d        = ST_PLAY;
                    player_count_d = clamp_players(bus.player_count_in);
                    score_d        = '0;
                    winner_d       = NO_WINNER;
`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
                    round_d        = '0;
`endif
                end
            end

            ST_PLAY: begin
                // An event accepted in the cycle the end condition is seen
                // still lands; the scan then reads the final scores.
                if (award_hit && player_ok) begin
                    score_d[award_sel] = sat_score;
`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
                    round_d            = round_q + 5'd1;
`endif
                end
                if (end_hit) begin
                    state_d      = ST_RESOLVE;
                    scan_idx_d   = 3'd1;
                    best_idx_d   = 3'd1;
                    best_score_d = '0;
                end
            end

            ST_RESOLVE: begin
                // First player seeds the scan; later ones replace only on a
                // strictly greater score so ties keep the lowest index.
                take = (scan_idx_q == 3'd1) || (scan_score > best_score_q);
                if (take) begin
                    best_idx_d   = scan_idx_q;
                    best_score_d = scan_score;
                end
                if (scan_idx_q == player_count_q) begin
                    state_d   = ST_DONE;
                    winner_d  = take ? scan_idx_q : best_idx_q;
                    win_req_d = 1'b1;
                end else begin
                    scan_idx_d = scan_idx_q + 3'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the scores are a handful of flops, not a RAM, so they are reset
    // along with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            player_count_q <= 3'd1;
            score_q        <= '0;
            winner_q       <= NO_WINNER;
            win_req_q      <= 1'b0;
            scan_idx_q     <= 3'd1;
            best_idx_q     <= 3'd1;
            best_score_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state_q        <= state_d;
            player_count_q <= player_count_d;
            score_q        <= score_d;
            winner_q       <= winner_d;
            win_req_q      <= win_req_d;
            scan_idx_q     <= scan_idx_d;
            best_idx_q     <= best_idx_d;
            best_score_q   <= best_score_d;
        end
    end

`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
        end else begin
            round_q <= round_d;
        end
    end
`endif

    assign bus.player_count  = player_count_q;
    assign bus.player1_score = score_q[0];
    assign bus.player2_score = score_q[1];
    assign bus.player3_score = score_q[2];
    assign bus.player4_score = score_q[3];
    assign bus.winner        = winner_q;
    assign bus.game_over     = (state_q == ST_DONE);
    assign bus.win_req       = win_req_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: table of scoring events with
// hand-computed scores, plus directed sequences for resolve, ties and reset.
module tb_score_keeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus, fanned out to every DUT instance.
    logic       start_s  = 1'b0;
    logic [2:0] pcin_s   = 3'd0;
    logic       valid_s  = 1'b0;
    logic [2:0] player_s = 3'd0;
    logic       sub_s    = 1'b0;
    logic [3:0] pts_s    = 4'd0;

    score_keeper_if b0 ();
    score_keeper_if b1 ();

    score_keeper #(.WIN_SCORE(30)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    score_keeper #(.WIN_SCORE(99)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    assign b0.start = start_s;  assign b0.player_count_in = pcin_s;
    assign b0.award_valid = valid_s;  assign b0.award_player = player_s;
    assign b0.award_sub = sub_s;  assign b0.award_pts = pts_s;
    assign b1.start = start_s;  assign b1.player_count_in = pcin_s;
    assign b1.award_valid = valid_s;  assign b1.award_player = player_s;
    assign b1.award_sub = sub_s;  assign b1.award_pts = pts_s;

    typedef struct packed {
        logic       ready;
        logic [2:0] pc;
        logic [6:0] s1, s2, s3, s4;
        logic [2:0] winner;
        logic       game_over;
        logic       win_req;
    } obs_t;

    obs_t o0, o1, o2, obs;
    int   sel = 0;

    assign o0 = {b0.award_ready, b0.player_count, b0.player1_score, b0.player2_score,
                 b0.player3_score, b0.player4_score, b0.winner, b0.game_over, b0.win_req};
    assign o1 = {b1.award_ready, b1.player_count, b1.player1_score, b1.player2_score,
                 b1.player3_score, b1.player4_score, b1.winner, b1.game_over, b1.win_req};

`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
    score_keeper_if b2 ();
    score_keeper #(.WIN_SCORE(30), .MAX_ROUNDS(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    assign b2.start = start_s;  assign b2.player_count_in = pcin_s;
    assign b2.award_valid = valid_s;  assign b2.award_player = player_s;
    assign b2.award_sub = sub_s;  assign b2.award_pts = pts_s;
    assign o2 = {b2.award_ready, b2.player_count, b2.player1_score, b2.player2_score,
                 b2.player3_score, b2.player4_score, b2.winner, b2.game_over, b2.win_req};
`else
    assign o2 = '0;
`endif

    always_comb begin
        obs = o0;
        if (sel == 1) obs = o1;
        else if (sel == 2) obs = o2;
    end

    typedef struct {
        logic [2:0] player;
        logic       sub;
        logic [3:0] pts;
        int         exp_score;
    } award_vec_t;

    award_vec_t tbl[$];
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int score_of(input int p);
        case (p)
            1:       return int'(obs.s1);
            2:       return int'(obs.s2);
            3:       return int'(obs.s3);
            4:       return int'(obs.s4);
            default: return -1;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the start.
    task automatic start_game(input logic [2:0] n);
        start_s = 1'b1;
        pcin_s  = n;
        @(posedge clk); #1;
        start_s = 1'b0;
    endtask

    // Presents one event and returns #1 after the edge that accepted it.
    task automatic award(input logic [2:0] p, input logic s, input logic [3:0] n);
        int waited = 0;
        valid_s  = 1'b1;
        player_s = p;
        sub_s    = s;
        pts_s    = n;
        @(negedge clk);
        while (!obs.ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!obs.ready) check("award_ready_timeout", 0, 1);
        @(posedge clk); #1;
        valid_s = 1'b0;
    endtask

    task automatic play(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            award(tbl[i].player, tbl[i].sub, tbl[i].pts);
            check($sformatf("score_vec%0d_p%0d", i, tbl[i].player),
                  score_of(int'(tbl[i].player)), tbl[i].exp_score);
        end
    endtask

    // Counts edges until win_req, then checks the DONE entry and the cycle after.
    task automatic wait_done(input int exp_edges, input int exp_winner);
        int  n     = 0;
        bit  early = 1'b0;
        while (!obs.win_req && n < 40) begin
            if (obs.winner != 3'd0 || obs.game_over) early = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("resolve_edges", n, exp_edges);
        check("winner_zero_before_done", int'(early), 0);
        check("winner_on_done", int'(obs.winner), exp_winner);
        check("game_over_on_done", int'(obs.game_over), 1);
        @(posedge clk); #1;
        check("win_req_one_cycle", int'(obs.win_req), 0);
        check("winner_stable", int'(obs.winner), exp_winner);
        check("game_over_stays", int'(obs.game_over), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Saturation game (WIN_SCORE=99 instance), entries 0..9
        tbl.push_back('{3'd3, 1'b0, 4'd5,  5});
        tbl.push_back('{3'd3, 1'b1, 4'd9,  0});
        tbl.push_back('{3'd1, 1'b1, 4'd3,  0});
        tbl.push_back('{3'd2, 1'b0, 4'd15, 15});
        tbl.push_back('{3'd2, 1'b0, 4'd15, 30});
        tbl.push_back('{3'd2, 1'b0, 4'd15, 45});
        tbl.push_back('{3'd2, 1'b0, 4'd15, 60});
        tbl.push_back('{3'd2, 1'b0, 4'd15, 75});
        tbl.push_back('{3'd2, 1'b0, 4'd15, 90});
        tbl.push_back('{3'd2, 1'b0, 4'd15, 99});
        // Game A, entries 10..11
        tbl.push_back('{3'd1, 1'b0, 4'd15, 15});
        tbl.push_back('{3'd1, 1'b0, 4'd15, 30});
        // Game B (tie broken by later increment), entries 12..16
        tbl.push_back('{3'd2, 1'b0, 4'd15, 15});
        tbl.push_back('{3'd2, 1'b0, 4'd10, 25});
        tbl.push_back('{3'd3, 1'b0, 4'd15, 15});
        tbl.push_back('{3'd3, 1'b0, 4'd10, 25});
        tbl.push_back('{3'd3, 1'b0, 4'd5,  30});
        // Game C (P1 and P3 both at 30), entries 17..22
        tbl.push_back('{3'd1, 1'b0, 4'd15, 15});
        tbl.push_back('{3'd1, 1'b0, 4'd14, 29});
        tbl.push_back('{3'd3, 1'b0, 4'd15, 15});
        tbl.push_back('{3'd3, 1'b0, 4'd14, 29});
        tbl.push_back('{3'd1, 1'b0, 4'd1,  30});
        tbl.push_back('{3'd3, 1'b0, 4'd1,  30});
        // Game D (4 players), entries 23..25
        tbl.push_back('{3'd4, 1'b0, 4'd10, 10});
        tbl.push_back('{3'd4, 1'b0, 4'd15, 25});
        tbl.push_back('{3'd4, 1'b0, 4'd5,  30});
        // Game E (1 player), entries 26..28
        tbl.push_back('{3'd2, 1'b0, 4'd5,  0});
        tbl.push_back('{3'd1, 1'b0, 4'd15, 15});
        tbl.push_back('{3'd1, 1'b0, 4'd15, 30});
        // Round-limit game, entries 29..32
        tbl.push_back('{3'd1, 1'b0, 4'd3,  3});
        tbl.push_back('{3'd2, 1'b0, 4'd5,  5});
        tbl.push_back('{3'd1, 1'b0, 4'd2,  5});
        tbl.push_back('{3'd2, 1'b0, 4'd1,  6});

        repeat (2) @(posedge clk);
        #1;
        check("rst_winner", int'(obs.winner), 0);
        check("rst_player_count", int'(obs.pc), 1);
        check("rst_game_over", int'(obs.game_over), 0);
        check("rst_win_req", int'(obs.win_req), 0);
        check("rst_award_ready", int'(obs.ready), 0);
        check("rst_scores", int'(obs.s1) + int'(obs.s2) + int'(obs.s3) + int'(obs.s4), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Saturation at 99 and at 0
        sel = 1;
        start_game(3'd4);
        check("sat_player_count", int'(obs.pc), 4);
        play(0, 9);
        wait_done(5, 2);

        // Game A: P1 reaches 30, two-cycle scan
        sel = 0;
        start_game(3'd2);
        check("a_player_count", int'(obs.pc), 2);
        check("a_ready_in_play", int'(obs.ready), 1);
        play(10, 11);
        wait_done(3, 1);

        // Game B: P3 overtakes P2
        start_game(3'd3);
        check("b_cleared_winner", int'(obs.winner), 0);
        check("b_cleared_game_over", int'(obs.game_over), 0);
        check("b_cleared_p1", int'(obs.s1), 0);
        play(12, 16);
        wait_done(4, 3);

        // Game C: equal top scores, lowest index wins
        start_game(3'd3);
        play(17, 22);
        check("c_p1_frozen", int'(obs.s1), 30);
        wait_done(3, 1);

        // Game D: clamp 7 -> 4, start during PLAY ignored
        start_game(3'd7);
        check("d_player_count_clamped", int'(obs.pc), 4);
        play(23, 23);
        start_game(3'd1);
        check("d_start_ignored_pc", int'(obs.pc), 4);
        check("d_start_ignored_p4", int'(obs.s4), 10);
        check("d_start_ignored_ready", int'(obs.ready), 1);
        play(24, 25);
        wait_done(5, 4);

        // Game E: clamp 0 -> 1, out-of-range award, reset mid-RESOLVE
        start_game(3'd0);
        check("e_player_count_clamped", int'(obs.pc), 1);
        check("e_p4_cleared", int'(obs.s4), 0);
        play(26, 26);
        check("e_oob_all_scores", int'(obs.s1) + int'(obs.s2) + int'(obs.s3) + int'(obs.s4), 0);
        play(27, 28);
        @(posedge clk); #1;
        check("e_resolve_no_game_over", int'(obs.game_over), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("e_rst_win_req", int'(obs.win_req), 0);
        check("e_rst_winner", int'(obs.winner), 0);
        check("e_rst_game_over", int'(obs.game_over), 0);
        check("e_rst_p1", int'(obs.s1), 0);
        check("e_rst_player_count", int'(obs.pc), 1);
        check("e_rst_ready", int'(obs.ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("e_no_late_win_req", int'(obs.win_req), 0);

`ifdef SCORE_KEEPER_ROUND_LIMIT_EN
        // Round limit of 4 ends the game below WIN_SCORE
        sel = 2;
        start_game(3'd2);
        play(29, 32);
        wait_done(3, 2);
        check("rl_p1", int'(obs.s1), 5);
        check("rl_p2", int'(obs.s2), 6);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
